inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1, exception redirect from WB.
REQ-004 SHALL have port ex_entry, input, 32, exception entry address.
REQ-005 SHALL have port ertn_valid, input, 1, exception-return redirect from WB.
REQ-006 SHALL have port era, input, 32, exception-return address.
REQ-007 SHALL have port br_taken, input, 1, branch redirect from ID/EX.
REQ-008 SHALL have port br_target, input, 32, branch target.
REQ-009 SHALL have port inst_sram_req, output, 1, bus request.
REQ-010 SHALL have port inst_sram_addr, output, 32, bus request address.
REQ-011 SHALL have port inst_sram_addr_ok, input, 1, request accepted.
REQ-012 SHALL have port inst_sram_data_ok, input, 1, read data returned.
REQ-013 SHALL have port inst_sram_rdata, input, 32, read data.
REQ-014 SHALL have port if_allowin, input, 1, IF stage can accept.
REQ-015 SHALL have port fs_valid, output, 1, instruction valid toward IF.
REQ-016 SHALL have port fs_pc, output, 32, PC of the presented instruction.
REQ-017 SHALL have port fs_inst, output, 32, presented instruction.
REQ-018 SHALL have port fs_adef, output, 1, address-error flag; 0 unless FETCH_ADEF_CHECK_EN.

Function
REQ-019 SHALL run FSM states IDLE, REQ, WAIT, DISCARD.
- IDLE -> REQ when buffer empty or being drained this cycle.
- REQ -> WAIT on req&addr_ok.
- WAIT -> IDLE on data_ok.
- DISCARD -> IDLE on data_ok.
REQ-020 SHALL hold inst_sram_req=1 and inst_sram_addr stable in REQ until addr_ok; req=0 in every other state.
REQ-021 SHALL choose redirect priority ex_valid > ertn_valid > br_taken when several occur in one cycle.
REQ-022 SHALL, on a redirect in IDLE, make the next request address the redirect target.
REQ-023 SHALL, on a redirect in REQ or WAIT, latch the target into a pending register.
- Redirect in WAIT, or in REQ coinciding with addr_ok: enter DISCARD.
- Redirect in REQ without addr_ok: keep requesting the old address and go to DISCARD on its addr_ok.
REQ-024 SHALL drop data returned in DISCARD (fs_valid not asserted), then issue at the pending target.
REQ-025 SHALL let a later redirect overwrite the pending target, subject to REQ-021 priority within a cycle.
REQ-026 SHALL otherwise issue sequential addresses; next = last issued + 4, 32-bit wrap at 0xFFFFFFFC -> 0x00000000.
REQ-027 SHALL hold returned data in a one-entry buffer when if_allowin=0; fs_valid=1 while the buffer is full.
REQ-028 SHALL pass data_ok data to fs_* in the same cycle when the buffer is empty and if_allowin=1.
REQ-029 SHALL not issue a request while the buffer is full.
REQ-030 SHALL flush the buffer (fs_valid=0 next cycle) on any redirect.

Reset
REQ-031 SHALL, while rst=1, force state IDLE, next address 0x1C000000, pending flag 0, buffer empty.
REQ-032 SHALL hold outputs at inst_sram_req=0, fs_valid=0, fs_pc=0, fs_inst=0, fs_adef=0 during reset.
REQ-033 SHALL, on rst asserted mid-transaction, abandon it; a data_ok arriving after reset is ignored.

Configuration
REQ-034 SHALL gate address-error checking on the macro FETCH_ADEF_CHECK_EN.
- Defined: a next address with addr[1:0]!=0 issues no bus request; fs_valid=1, fs_adef=1 and fs_pc=that address are presented, and the FSM stays in IDLE until a redirect.
- Undefined: no check is made and fs_adef is tied to 0.

Structure
REQ-035 SHALL put the FSM state encoding, reset PC 0x1C000000 and the PC step constant in shared package cpu_defs_pkg.
REQ-036 SHALL implement the one-entry output buffer as sub-module fetch_skid_buf.

Verification
REQ-037 SHALL cover: after reset, addr_ok and data_ok each returned 1 cycle after the request -> requests issued at 0x1C000000, 0x1C000004 and 0x1C000008.
REQ-038 SHALL cover: br_taken with target 0x1C000100 in WAIT -> the old data is dropped and the next request is at 0x1C000100.
REQ-039 SHALL cover: ex_valid (0x1C008000) and br_taken in the same cycle -> the next request is at 0x1C008000.
REQ-040 SHALL cover: if_allowin=0 for 3 cycles at data_ok -> fs_valid held with stable fs_inst and no new request; the instruction is released when if_allowin=1.
REQ-041 SHALL cover: br_target 0x1C000102 with FETCH_ADEF_CHECK_EN defined -> no request, fs_adef=1, fs_pc=0x1C000102.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared fetch-side definitions: fetch FSM encoding, reset PC and sequential PC step.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWait    = 2'd2,
        StDiscard = 2'd3
    } fetch_state_e;

    localparam logic [31:0] ResetPc = 32'h1C00_0000;
    localparam logic [31:0] PcStep  = 32'd4;

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PcStep;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry output buffer between the instruction bus and the IF stage.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_inst_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    output logic        full_o
);

    logic        full_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (full_q) begin
            if (out_ready_i) begin
                full_q <= 1'b0;
            end
        end else if (in_valid_i && !out_ready_i) begin
            full_q <= 1'b1;
            pc_q   <= in_pc_i;
            inst_q <= in_inst_i;
        end
    end

    // The fetch FSM never returns data while the entry is occupied.
    always_comb begin
        out_valid_o = full_q | in_valid_i;
        out_pc_o    = '0;
        out_inst_o  = '0;
        if (full_q) begin
            out_pc_o   = pc_q;
            out_inst_o = inst_q;
        end else if (in_valid_i) begin
            out_pc_o   = in_pc_i;
            out_inst_o = in_inst_i;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: sequential/redirected PC generation over an addr_ok/data_ok bus.
// Optional misaligned-PC trap enabled by defining FETCH_ADEF_CHECK_EN.
module inst_fetch_ctrl
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_entry,
    input  logic        ertn_valid,
    input  logic [31:0] era,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        if_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;       // next address to issue, or the in-flight one in StWait
    logic         pend_q;
    logic [31:0]  pend_pc_q;

    logic        redirect;
    logic [31:0] redir_pc;
    logic [31:0] idle_target;
    logic        target_bad;
    logic        adef_hold;
    logic        data_take;
    logic        buf_full;
    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;

    always_comb begin
        redirect = ex_valid | ertn_valid | br_taken;
        if (ex_valid) begin
            redir_pc = ex_entry;
        end else if (ertn_valid) begin
            redir_pc = era;
        end else begin
            redir_pc = br_target;
        end
    end

    assign idle_target = redirect ? redir_pc : pc_q;

`ifdef FETCH_ADEF_CHECK_EN
    assign target_bad = |idle_target[1:0];
    assign adef_hold  = (state_q == StIdle) && (|pc_q[1:0]);
`else
    assign target_bad = 1'b0;
    assign adef_hold  = 1'b0;
`endif

    // Data racing a redirect belongs to the abandoned path.
    assign data_take = !rst && (state_q == StWait) && inst_sram_data_ok && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= ResetPc;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    pc_q <= idle_target;
                    if ((redirect || !buf_full || if_allowin) && !target_bad) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_pc;
                    end
                    if (inst_sram_addr_ok) begin
                        state_q <= (redirect || pend_q) ? StDiscard : StWait;
                    end
                end
                StWait: begin
                    if (inst_sram_data_ok) begin
                        state_q <= StIdle;
                        pc_q    <= redirect ? redir_pc : pc_next(pc_q);
                    end else if (redirect) begin
                        state_q   <= StDiscard;
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_pc;
                    end
                end
                StDiscard: begin
                    if (inst_sram_data_ok) begin
                        state_q <= StIdle;
                        pend_q  <= 1'b0;
                        pc_q    <= redirect ? redir_pc : pend_pc_q;
                    end else if (redirect) begin
                        pend_pc_q <= redir_pc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inst_sram_req  = !rst && (state_q == StReq);
    assign inst_sram_addr = pc_q;

    fetch_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .in_valid_i  (data_take),
        .in_pc_i     (pc_q),
        .in_inst_i   (inst_sram_rdata),
        .out_ready_i (if_allowin),
        .out_valid_o (buf_valid),
        .out_pc_o    (buf_pc),
        .out_inst_o  (buf_inst),
        .full_o      (buf_full)
    );

    always_comb begin
        fs_valid = buf_valid;
        fs_pc    = buf_pc;
        fs_inst  = buf_inst;
        fs_adef  = 1'b0;
        if (adef_hold) begin
            fs_valid = 1'b1;
            fs_pc    = pc_q;
            fs_inst  = '0;
            fs_adef  = 1'b1;
        end
        if (rst) begin
            fs_valid = 1'b0;
            fs_pc    = '0;
            fs_inst  = '0;
            fs_adef  = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: per-cycle vector table plus reset/wrap sequences.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RST  = 32'h1C00_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] I0   = 32'hA000_0000;
    localparam logic [31:0] I1   = 32'hA000_0011;
    localparam logic [31:0] I2   = 32'hA000_0022;
    localparam logic [31:0] I3   = 32'hA000_0033;
    localparam logic [31:0] I4   = 32'hA000_0044;
    localparam logic [31:0] I5   = 32'hA000_0055;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ertn_valid, br_taken;
    logic [31:0] ex_entry, era, br_target;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        if_allowin;
    logic        fs_valid;
    logic [31:0] fs_pc, fs_inst;
    logic        fs_adef;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .ex_entry          (ex_entry),
        .ertn_valid        (ertn_valid),
        .era               (era),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .if_allowin        (if_allowin),
        .fs_valid          (fs_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst),
        .fs_adef           (fs_adef)
    );

    typedef struct {
        logic        ex;
        logic [31:0] ex_a;
        logic        ertn;
        logic [31:0] era_a;
        logic        br;
        logic [31:0] br_a;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        allow;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adef;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic aok, input logic dok, input logic [31:0] rd,
                               input logic allow, input logic e_req, input logic [31:0] e_addr,
                               input logic e_fv, input logic [31:0] e_pc,
                               input logic [31:0] e_inst);
        vec_t t;
        t.ex = 1'b0;  t.ex_a = '0;  t.ertn = 1'b0; t.era_a = '0;
        t.br = 1'b0;  t.br_a = '0;
        t.aok = aok;  t.dok = dok;  t.rd = rd;     t.allow = allow;
        t.e_req = e_req; t.e_addr = e_addr; t.e_fv = e_fv;
        t.e_pc = e_pc;   t.e_inst = e_inst; t.e_adef = 1'b0;
        return t;
    endfunction

    // kind: 0 = exception, 1 = ertn, 2 = branch
    function automatic vec_t rdr(input vec_t t, input int kind, input logic [31:0] a);
        vec_t r;
        r = t;
        if (kind == 0) begin
            r.ex = 1'b1; r.ex_a = a;
        end else if (kind == 1) begin
            r.ertn = 1'b1; r.era_a = a;
        end else begin
            r.br = 1'b1; r.br_a = a;
        end
        return r;
    endfunction

    task automatic clr();
        ex_valid = 1'b0; ex_entry = '0; ertn_valid = 1'b0; era = '0;
        br_taken = 1'b0; br_target = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        if_allowin = 1'b1;
    endtask

    task automatic drive(input vec_t t);
        ex_valid = t.ex;     ex_entry = t.ex_a;   ertn_valid = t.ertn; era = t.era_a;
        br_taken = t.br;     br_target = t.br_a;
        inst_sram_addr_ok = t.aok; inst_sram_data_ok = t.dok; inst_sram_rdata = t.rd;
        if_allowin = t.allow;
    endtask

    // Samples 1 ns after the input change, then advances to the next falling edge.
    task automatic chk(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_fv, input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_adef);
        logic ok;
        #1;
        ok = (inst_sram_req === e_req) && (!e_req || inst_sram_addr === e_addr) &&
             (fs_valid === e_fv) && (!e_fv || (fs_pc === e_pc && fs_inst === e_inst)) &&
             (fs_adef === e_adef);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h fv=%b pc=%h inst=%h adef=%b; want req=%b addr=%h fv=%b pc=%h inst=%h adef=%b",
                     name, inst_sram_req, inst_sram_addr, fs_valid, fs_pc, fs_inst, fs_adef,
                     e_req, e_addr, e_fv, e_pc, e_inst, e_adef);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = JUNK;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (!(inst_sram_req === 1'b0 && fs_valid === 1'b0 && fs_pc === 32'h0 &&
                  fs_inst === 32'h0 && fs_adef === 1'b0)) begin
                n_fail++;
                $display("FAIL reset%0d: got req=%b fv=%b pc=%h inst=%h adef=%b; want all zero",
                         k, inst_sram_req, fs_valid, fs_pc, fs_inst, fs_adef);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        clr();
    endtask

    initial begin
        vec_t t;
        // Sequential fetch with one-cycle addr_ok/data_ok latency.
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        vq.push_back(v(0, 0, 0,  1, 1, RST,     0, 0, 0));
        vq.push_back(v(1, 0, 0,  1, 1, RST,     0, 0, 0));
        vq.push_back(v(0, 1, I0, 1, 0, 0,       1, RST, I0));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        vq.push_back(v(1, 0, 0,  1, 1, RST + 4, 0, 0, 0));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        vq.push_back(v(0, 1, I1, 1, 0, 0,       1, RST + 4, I1));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        vq.push_back(v(1, 0, 0,  1, 1, RST + 8, 0, 0, 0));
        // Branch while waiting: old data dropped, refetch at target.
        vq.push_back(rdr(v(0, 0, 0, 1, 0, 0, 0, 0, 0), 2, 32'h1C00_0100));
        vq.push_back(v(0, 1, JUNK, 1, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        // Exception and branch together with addr_ok: exception wins.
        vq.push_back(rdr(rdr(v(1, 0, 0, 1, 1, 32'h1C00_0100, 0, 0, 0), 0, 32'h1C00_8000),
                         2, 32'h1C00_0200));
        vq.push_back(v(0, 1, JUNK, 1, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        // Redirect in REQ without addr_ok, then overwritten while discarding.
        vq.push_back(rdr(v(0, 0, 0, 1, 1, 32'h1C00_8000, 0, 0, 0), 1, 32'h1C00_3000));
        vq.push_back(v(1, 0, 0,  1, 1, 32'h1C00_8000, 0, 0, 0));
        vq.push_back(rdr(v(0, 0, 0, 1, 0, 0, 0, 0, 0), 2, 32'h1C00_0400));
        vq.push_back(v(0, 1, JUNK, 1, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0,  1, 0, 0,       0, 0, 0));
        vq.push_back(v(1, 0, 0,  1, 1, 32'h1C00_0400, 0, 0, 0));
        // IF stalled for three cycles: buffered instruction held, no new request.
        vq.push_back(v(0, 1, I2, 0, 0, 0, 1, 32'h1C00_0400, I2));
        vq.push_back(v(0, 0, 0,  0, 0, 0, 1, 32'h1C00_0400, I2));
        vq.push_back(v(0, 0, 0,  0, 0, 0, 1, 32'h1C00_0400, I2));
        vq.push_back(v(0, 0, 0,  1, 0, 0, 1, 32'h1C00_0400, I2));
        vq.push_back(v(1, 0, 0,  1, 1, 32'h1C00_0404, 0, 0, 0));
        vq.push_back(v(0, 1, I3, 0, 0, 0, 1, 32'h1C00_0404, I3));
        // Branch to a misaligned target flushes the full buffer.
        vq.push_back(rdr(v(0, 0, 0, 0, 0, 0, 1, 32'h1C00_0404, I3), 2, 32'h1C00_0102));
        for (int k = 0; k < 2; k++) begin
`ifdef FETCH_ADEF_CHECK_EN
            t = v(0, 0, 0, 1, 0, 0, 1, 32'h1C00_0102, 0);
            t.e_adef = 1'b1;
`else
            t = v(0, 0, 0, 1, 1, 32'h1C00_0102, 0, 0, 0);
`endif
            vq.push_back(t);
        end

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            chk($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_fv,
                vq[i].e_pc, vq[i].e_inst, vq[i].e_adef);
        end

        // Reset mid-transaction; data_ok after reset must be ignored.
        do_reset();
        inst_sram_data_ok = 1'b1; inst_sram_rdata = JUNK;
        chk("rst_dok_ignored", 0, 0, 0, 0, 0, 0);
        clr(); inst_sram_addr_ok = 1'b1;
        chk("restart_req", 1, RST, 0, 0, 0, 0);
        clr(); rst = 1'b1;
        chk("mid_rst", 0, 0, 0, 0, 0, 0);
        clr(); rst = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = JUNK;
        chk("post_rst_dok", 0, 0, 0, 0, 0, 0);
        clr();
        chk("post_rst_req", 1, RST, 0, 0, 0, 0);
        inst_sram_addr_ok = 1'b1;
        chk("post_rst_req_ok", 1, RST, 0, 0, 0, 0);
        clr(); inst_sram_data_ok = 1'b1; inst_sram_rdata = I5;
        chk("post_rst_data", 0, 0, 1, RST, I5, 0);

        // ertn beats branch in IDLE; sequential wrap past 0xFFFFFFFC.
        clr(); ertn_valid = 1'b1; era = 32'hFFFF_FFFC; br_taken = 1'b1; br_target = RST;
        chk("prio_ertn", 0, 0, 0, 0, 0, 0);
        clr(); inst_sram_addr_ok = 1'b1;
        chk("wrap_req", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        clr(); inst_sram_data_ok = 1'b1; inst_sram_rdata = I4;
        chk("wrap_data", 0, 0, 1, 32'hFFFF_FFFC, I4, 0);
        clr();
        chk("wrap_idle", 0, 0, 0, 0, 0, 0);
        chk("wrap_next", 1, 32'h0000_0000, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
